cfg_frame_receiver: RTL

Receives the 32-bit configuration word stream that the host or bench drives on `SelfWriteData`/`SelfWriteStrobe`, and turns it into complete configuration frames for the fabric's frame registers. The block sits between the self-write port (and the UART/bit-bang front ends that share it) and the per-column frame-data/frame-strobe distribution of `eFPGA_top`. It locks onto a sync word, decodes one header per frame, and collects `NUM_ROWS` data words. It then issues a one-cycle frame-valid pulse carrying the frame data, column and frame index.

---
 rtl/cfg_frame_receiver_if.sv | 16 +
 rtl/cfg_frame_receiver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cfg_frame_receiver_if.sv
// cfg_frame_receiver_if
//   Self-write word stream shared by the host/bench and the UART/bit-bang
//   front ends. Each cycle with SelfWriteStrobe high carries one 32-bit word.
//   Ports (signals):
//     SelfWriteStrobe  1   word qualifier
//     SelfWriteData    32  configuration word
//   Modports:
//     master  drives the stream
//     slave   receives the stream (cfg_frame_receiver)
interface cfg_frame_receiver_if;
  logic        SelfWriteStrobe;
  logic [31:0] SelfWriteData;

  modport master (output SelfWriteStrobe, output SelfWriteData);
  modport slave  (input  SelfWriteStrobe, input  SelfWriteData);
endinterface

// File: rtl/cfg_frame_receiver.sv
// cfg_frame_receiver
//   Locks onto a sync word in the self-write stream, decodes one header per
//   frame and collects NUM_ROWS data words, then emits a one-cycle frame_valid
//   pulse with the assembled frame, its column and its frame index.
//   Ports:
//     CLK          in   clock, rising edge
//     rst          in   asynchronous active-high reset
//     cfg_in       if   self-write stream (slave modport)
//     frame_data   out  NUM_ROWS*32 assembled frame, first word in the MSBs
//     frame_col    out  8  column index from the header
//     frame_idx    out  5  frame index from the header
//     frame_valid  out  1  one-cycle pulse, frame outputs valid while high
//     synced       out  1  high in every state except IDLE
//     cfg_err      out  1  sticky header error flag
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | unsynced, waiting for SYNC_WORD
//   HEADER   | synced, next non-sync word is a header (DESYNC leaves)
//   DATA     | collecting NUM_ROWS data words of an accepted header
//   DISCARD  | swallowing NUM_ROWS words that follow a rejected header
module cfg_frame_receiver #(
  parameter int          NUM_ROWS       = 34,
  parameter int          NUM_COLS       = 60,
  parameter int          FRAMES_PER_COL = 20,
  parameter logic [31:0] SYNC_WORD      = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD    = 32'hFAB0_FAB0
) (
  input  logic                     CLK,
  input  logic                     rst,
  cfg_frame_receiver_if.slave      cfg_in,
  output logic [NUM_ROWS*32-1:0]   frame_data,
  output logic [7:0]               frame_col,
  output logic [4:0]               frame_idx,
  output logic                     frame_valid,
  output logic                     synced,
  output logic                     cfg_err
);

  localparam int FW    = NUM_ROWS * 32;
  localparam int CNT_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_DATA    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [FW-1:0]    buffer;
  logic [FW-1:0]    buf_shift;
  logic [7:0]       hdr_col;
  logic [4:0]       hdr_idx;

  logic        strobe;
  logic [31:0] word;
  logic        is_sync;
  logic        is_desync;
  logic        hdr_ok;
  logic        last_word;

  // Control strobes produced by the output process.
  logic clr_err;
  logic set_err;
  logic latch_hdr;
  logic shift_word;
  logic count_word;
  logic emit_frame;

  assign strobe    = cfg_in.SelfWriteStrobe;
  assign word      = cfg_in.SelfWriteData;
  assign is_sync   = (word == SYNC_WORD);
  assign is_desync = (word == DESYNC_WORD);
  assign hdr_ok    = (int'(word[15:8]) < NUM_COLS) && (int'(word[4:0]) < FRAMES_PER_COL);
  assign last_word = (cnt == CNT_LAST);
  // Shift form that stays legal for NUM_ROWS == 1.
  assign buf_shift = (buffer << 32) | FW'(word);

  // State register
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; nothing moves without a strobe.
  always_comb begin
    state_nxt = state;
    if (strobe) begin
      case (state)
        S_IDLE: begin
          if (is_sync) state_nxt = S_HEADER;
        end
        S_HEADER: begin
          if (is_desync)     state_nxt = S_IDLE;
          else if (!is_sync) state_nxt = hdr_ok ? S_DATA : S_DISCARD;
        end
        S_DATA: begin
          if (last_word) state_nxt = S_HEADER;
        end
        S_DISCARD: begin
          if (last_word) state_nxt = S_HEADER;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Output/control decode
  always_comb begin
    clr_err    = 1'b0;
    set_err    = 1'b0;
    latch_hdr  = 1'b0;
    shift_word = 1'b0;
    count_word = 1'b0;
    emit_frame = 1'b0;
    if (strobe) begin
      case (state)
        S_IDLE: begin
          clr_err = is_sync;
        end
        S_HEADER: begin
          if (!is_desync && !is_sync) begin
            latch_hdr = hdr_ok;
            set_err   = !hdr_ok;
          end
        end
        S_DATA: begin
          shift_word = 1'b1;
          count_word = 1'b1;
          emit_frame = last_word;
        end
        S_DISCARD: begin
          count_word = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      buffer      <= '0;
      hdr_col     <= '0;
      hdr_idx     <= '0;
      frame_data  <= '0;
      frame_col   <= '0;
      frame_idx   <= '0;
      frame_valid <= 1'b0;
      synced      <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      frame_valid <= emit_frame;
      synced      <= (state_nxt != S_IDLE);

      if (count_word) cnt <= last_word ? '0 : cnt + CNT_W'(1);
      if (shift_word) buffer <= buf_shift;

      if (latch_hdr) begin
        hdr_col <= word[15:8];
        hdr_idx <= word[4:0];
      end

      if (emit_frame) begin
        frame_data <= buf_shift;
        frame_col  <= hdr_col;
        frame_idx  <= hdr_idx;
      end

      if (clr_err)      cfg_err <= 1'b0;
      else if (set_err) cfg_err <= 1'b1;
    end
  end

endmodule
